// File: rtl/seg7_scan_ctrl_pkg.sv
// Purpose: shared types, constants and helpers for the seven-segment scan controller.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package seg7_pkg;

  // Scan phases: all-off guard interval, then one digit lit.
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Active-low cathode pattern with every segment and the decimal point dark.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Widest display supported; nibble images are carried at this width.
  localparam int MAX_DIGITS = 8;

  // Leading-zero candidates: bit i is set when nibbles i..n-1 are all zero.
  // Digit 0 is never flagged, so a zero value still shows a single "0".
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] value,
                                                    input int n);
    logic [MAX_DIGITS-1:0] m;
    logic                  zero_run;
    m        = '0;
    zero_run = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < n) begin
        zero_run = zero_run & (value[i*4 +: 4] == 4'h0);
        m[i]     = zero_run & (i != 0);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Purpose: SoC-side bundle for the scan controller (image load, options, display pins).
// Latency: n/a (wires only).
// Backpressure: none; load is a fire-and-forget strobe, updated reports the commit.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    lz_suppress;
  logic [NUM_DIGITS-1:0]   anodes;
  logic [7:0]              cathodes;
  logic                    updated;

  // Register/status logic side.
  modport master (
    output load, value, digit_en, dp, lz_suppress,
    input  anodes, cathodes, updated
  );

  // Scan controller side.
  modport slave (
    input  load, value, digit_en, dp, lz_suppress,
    output anodes, cathodes, updated
  );
endinterface

// File: rtl/seg7_scan_ctrl_hex2physical.sv
// Purpose: hex nibble to active-low seven-segment pattern; hex[4] enables the digit.
// Latency: combinational.
// Backpressure: none.
module hex2physical (
  input  logic [4:0] hex,
  output logic [7:0] seg
);

  // Decode bit order {dp,g,f,e,d,c,b,a}, active low; dp always dark here.
  always_comb begin
    seg = 8'hFF;
    if (hex[4]) begin
      case (hex[3:0])
        4'h0:    seg = 8'hC0;
        4'h1:    seg = 8'hF9;
        4'h2:    seg = 8'hA4;
        4'h3:    seg = 8'hB0;
        4'h4:    seg = 8'h99;
        4'h5:    seg = 8'h92;
        4'h6:    seg = 8'h82;
        4'h7:    seg = 8'hF8;
        4'h8:    seg = 8'h80;
        4'h9:    seg = 8'h90;
        4'hA:    seg = 8'h88;
        4'hB:    seg = 8'h83;
        4'hC:    seg = 8'hC6;
        4'hD:    seg = 8'hA1;
        4'hE:    seg = 8'h86;
        default: seg = 8'h8E;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Purpose: time-multiplexed N-digit common-anode scan with double-buffered image.
// Latency: outputs registered; a load is shown from the frame after the next frame end.
// Backpressure: none; loads before commit overwrite pending, updated pulses on commit.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int ON_CYCLES    = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rstN,
  seg7_scan_ctrl_if.slave bus
);

  localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'(BLANK);
  localparam logic [0:0] ST_SHOW  = 1'(SHOW);

  logic [0:0]              r_state;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;

  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_en;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_en;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_vld;

  logic [NUM_DIGITS-1:0]   r_anodes;
  logic [7:0]              r_cathodes;
  logic                    r_updated;

  logic                    w_blank_done;
  logic                    w_show_done;
  logic                    w_frame_end;
  logic [MAX_DIGITS-1:0]   w_lz_all;
  logic                    w_lz_blank;
  logic [3:0]              w_nibble;
  logic                    w_visible;
  logic [7:0]              w_seg;

  assign w_blank_done = (r_state == ST_BLANK) && (r_cnt == BLANK_LAST);
  assign w_show_done  = (r_state == ST_SHOW) && (r_cnt == ON_LAST);
  assign w_frame_end  = w_show_done && (r_idx == IDX_LAST);

  // Visibility of the digit about to be shown; lz_suppress is taken live here,
  // so a change lands at the next slot start.
  assign w_lz_all   = lz_mask((4*MAX_DIGITS)'(r_act_val), NUM_DIGITS);
  assign w_lz_blank = bus.lz_suppress & w_lz_all[r_idx];
  assign w_nibble   = 4'(r_act_val >> {r_idx, 2'b00});
  assign w_visible  = r_act_en[r_idx] & ~w_lz_blank;

  // Single decoder shared by all digits; its enable blanks hidden digits.
  hex2physical u_hex2physical (
    .hex ({w_visible, w_nibble}),
    .seg (w_seg)
  );

  // Slot sequencer: BLANK guard, then SHOW for digit r_idx, advancing per slot.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else if (w_blank_done) begin
      r_state <= ST_SHOW;
      r_cnt   <= '0;
    end else if (w_show_done) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= w_frame_end ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Image buffers: loads park in pending, which is promoted only at frame end
  // so a frame is never drawn from two different images.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_act_val  <= '0;
      r_act_en   <= '0;
      r_act_dp   <= '0;
      r_pend_val <= '0;
      r_pend_en  <= '0;
      r_pend_dp  <= '0;
      r_pend_vld <= 1'b0;
      r_updated  <= 1'b0;
    end else begin
      r_updated <= 1'b0;
      if (bus.load && w_frame_end) begin
        // Load on the commit edge bypasses pending: newest data wins.
        r_act_val  <= bus.value;
        r_act_en   <= bus.digit_en;
        r_act_dp   <= bus.dp;
        r_pend_vld <= 1'b0;
        r_updated  <= 1'b1;
      end else begin
        if (bus.load) begin
          r_pend_val <= bus.value;
          r_pend_en  <= bus.digit_en;
          r_pend_dp  <= bus.dp;
          r_pend_vld <= 1'b1;
        end
        if (w_frame_end && r_pend_vld) begin
          r_act_val  <= r_pend_val;
          r_act_en   <= r_pend_en;
          r_act_dp   <= r_pend_dp;
          r_pend_vld <= 1'b0;
          r_updated  <= 1'b1;
        end
      end
    end
  end

  // Pin drivers: loaded at SHOW entry, cleared at SHOW exit; dark otherwise.
  // The decoder leaves bit 7 high, so the AND simply places our dp there.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_anodes   <= '1;
      r_cathodes <= SEG_OFF;
    end else if (w_blank_done) begin
      r_anodes   <= w_visible ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      r_cathodes <= {w_seg[7] & ~(w_visible & r_act_dp[r_idx]), w_seg[6:0]};
    end else if (w_show_done) begin
      r_anodes   <= '1;
      r_cathodes <= SEG_OFF;
    end
  end

  assign bus.anodes   = r_anodes;
  assign bus.cathodes = r_cathodes;
  assign bus.updated  = r_updated;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Purpose: directed self-checking bench for seg7_scan_ctrl (4 digits, 8 on, 2 blank).
// Latency: frame period 40 cycles; checks sampled on the falling edge.
// Backpressure: n/a.
module tb_seg7_scan_ctrl;

  logic clk;
  logic rstN;
  int   n_cmp;
  int   n_bad;

  seg7_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS   (4),
    .ON_CYCLES    (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] d);
    bus.value    = v;
    bus.digit_en = en;
    bus.dp       = d;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  // Advance to the falling edge where updated is high (frame cycle 0).
  task automatic wait_upd(input string tag);
    int n;
    n = 0;
    while (bus.updated !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.updated), 32'd1);
  endtask

  // Check one full 40-cycle frame starting at frame cycle 0.
  // cat packs the per-digit cathodes as {d3,d2,d1,d0}; vis marks lit digits.
  task automatic check_frame(input string tag, input logic [3:0] vis,
                             input logic [31:0] cat, input logic upd0);
    logic [12:0] exp_v;
    logic        u;
    for (int k = 0; k < 40; k++) begin
      int d;
      int pos;
      d   = k / 10;
      pos = k % 10;
      u   = (k == 0) ? upd0 : 1'b0;
      if (pos >= 2 && vis[d])
        exp_v = {u, ~(4'b0001 << d), cat[d*8 +: 8]};
      else
        exp_v = {u, 4'hF, 8'hFF};
      chk($sformatf("%s_c%0d", tag, k),
          32'({bus.updated, bus.anodes, bus.cathodes}), 32'(exp_v));
      @(negedge clk);
    end
  endtask

  initial begin
    n_cmp           = 0;
    n_bad           = 0;
    rstN            = 1'b0;
    bus.load        = 1'b0;
    bus.value       = '0;
    bus.digit_en    = '0;
    bus.dp          = '0;
    bus.lz_suppress = 1'b0;

    // 1: reset values, then an empty first slot stays dark.
    repeat (5) @(negedge clk);
    chk("rst_anodes",   32'(bus.anodes),   32'h0F);
    chk("rst_cathodes", 32'(bus.cathodes), 32'hFF);
    chk("rst_updated",  32'(bus.updated),  32'h0);
    rstN = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("t1_dark_c%0d", k),
          32'({bus.updated, bus.anodes, bus.cathodes}), 32'h0FFF);
      @(negedge clk);
    end

    // 2: plain image 1234, one commit pulse, then a frame with no pulse.
    do_load(16'h1234, 4'hF, 4'h0);
    wait_upd("t2_upd");
    check_frame("t2",  4'hF, {8'hF9, 8'hA4, 8'hB0, 8'h99}, 1'b1);
    check_frame("t2b", 4'hF, {8'hF9, 8'hA4, 8'hB0, 8'h99}, 1'b0);

    // 3: leading-zero suppression.
    bus.lz_suppress = 1'b1;
    do_load(16'h0050, 4'hF, 4'h0);
    wait_upd("t3_upd");
    check_frame("t3", 4'b0011, {8'hFF, 8'hFF, 8'h92, 8'hC0}, 1'b1);
    do_load(16'h0000, 4'hF, 4'h0);
    wait_upd("t3z_upd");
    check_frame("t3z", 4'b0001, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 1'b1);
    bus.lz_suppress = 1'b0;

    // 4: two loads before commit (last wins), then a load on the commit edge.
    do_load(16'hAAAA, 4'hF, 4'h0);
    repeat (10) @(negedge clk);
    do_load(16'hBBBB, 4'hF, 4'h0);
    wait_upd("t4_upd");
    check_frame("t4", 4'hF, {8'h83, 8'h83, 8'h83, 8'h83}, 1'b1);
    repeat (39) @(negedge clk);
    do_load(16'hC0DE, 4'hF, 4'h0);
    check_frame("t4c", 4'hF, {8'hC6, 8'hC0, 8'hA1, 8'h86}, 1'b1);
    check_frame("t4d", 4'hF, {8'hC6, 8'hC0, 8'hA1, 8'h86}, 1'b0);

    // 5: decimal point on digit 2 only.
    do_load(16'h8888, 4'hF, 4'b0100);
    wait_upd("t5_upd");
    check_frame("t5", 4'hF, {8'h80, 8'h00, 8'h80, 8'h80}, 1'b1);

    // 6: reset during digit 2 SHOW, then a cleared restart from digit 0.
    repeat (25) @(negedge clk);
    chk("t6_pre_anodes", 32'(bus.anodes), 32'h0B);
    #2;
    rstN = 1'b0;
    #1;
    chk("t6_rst_anodes",   32'(bus.anodes),   32'h0F);
    chk("t6_rst_cathodes", 32'(bus.cathodes), 32'hFF);
    chk("t6_rst_updated",  32'(bus.updated),  32'h0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 39; k++) begin
      chk($sformatf("t6_dark_c%0d", k),
          32'({bus.updated, bus.anodes, bus.cathodes}), 32'h0FFF);
      @(negedge clk);
    end
    do_load(16'h1357, 4'hF, 4'h0);
    check_frame("t6", 4'hF, {8'hF9, 8'hB0, 8'h92, 8'hF8}, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
